multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: op  in  7  opcode; funct3  in  3; funct7b5  in  1  (instr bit 30).
REQ-004 SHALL have ports: Zero  in  1  ALU zero flag; MemReady  in  1  memory access complete this cycle.
REQ-005 SHALL have ports: PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Illegal  out  1 each.
REQ-006 SHALL have ports: ResultSrc, ALUSrcA, ALUSrcB  out  2 each; ImmSrc, ALUControl  out  3 each.

Function
REQ-007 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, LUI, registered on clk.
REQ-008 SHALL emit these ALUControl codes: 000 add, 001 sub, 010 and, 011 or, 101 slt, 111 pass-B (lui), 100 xor (macro only).
REQ-009 FETCH: AdrSrc=0, ALUSrcA=00 (PC), ALUSrcB=10 (+4), add, ResultSrc=10; IRWrite=PCWrite=MemReady; stay in FETCH while MemReady=0, else go to DECODE.
REQ-010 DECODE: ALUSrcA=01 (oldPC), ALUSrcB=01 (imm), add; next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1101111 -> JAL, 1100011 -> BEQ, 0110111 -> LUI.
REQ-011 DECODE with unlisted op, or R/I-type with an unsupported funct3, SHALL set Illegal=1 for that cycle only and go to FETCH; no register or memory write SHALL occur.
REQ-012 MEMADR: ALUSrcA=10 (rs1), ALUSrcB=01, add; go to MEMREAD if op[5]=0, else MEMWRITE.
REQ-013 MEMREAD: AdrSrc=1, ResultSrc=00; hold until MemReady=1, then go to MEMWB.
REQ-014 MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
REQ-015 MEMWRITE: AdrSrc=1, MemWrite=1 every cycle held; leave to FETCH on the cycle MemReady=1.
REQ-016 EXECR: ALUSrcA=10, ALUSrcB=00; EXECI: ALUSrcA=10, ALUSrcB=01; both go to ALUWB.
REQ-017 ALU decode for R/I: funct3 000 -> sub if op[5]&funct7b5, else add; 010 -> 101; 110 -> 011; 111 -> 010; all other funct3 illegal (REQ-011).
REQ-018 ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
REQ-019 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB.
REQ-020 BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero, then FETCH.
REQ-021 LUI: ALUSrcB=01, ALUControl=111, then ALUWB.
REQ-022 ImmSrc SHALL be combinational from op: I 000, S 001, B 010, J 011, U 100, else 000.
REQ-023 Unlisted outputs in a state SHALL be 0; the state register SHALL only take encoded states, and any unreachable encoding SHALL go to FETCH.

Reset
REQ-024 While rst=1, state SHALL be FETCH and PCWrite, IRWrite, MemWrite, RegWrite and Illegal SHALL be forced to 0.
REQ-025 Reset asserted mid-instruction (including a held MEMWRITE) SHALL abort the instruction immediately, with no further write strobes.
REQ-026 After rst falls, the first edge SHALL evaluate FETCH normally.

Configuration
REQ-027 With ALU_XOR_EN defined, funct3=100 for R/I-type SHALL be legal and SHALL produce ALUControl=100.
REQ-028 Without ALU_XOR_EN, funct3=100 SHALL be illegal per REQ-011.

Verification
REQ-029 add x3,x1,x2 (op 0110011, f3 000, f7b5 0), MemReady=1 -> FETCH, DECODE, EXECR (ALUControl=000), ALUWB (RegWrite=1): 4 cycles.
REQ-030 lw, MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with ResultSrc=01 and RegWrite=1; 5+3 cycles total.
REQ-031 beq with Zero=1, then beq with Zero=0 -> BEQ state shows PCWrite=1, then 0; ALUControl=001 in both.
REQ-032 xor (f3 100) -> Illegal pulse and no RegWrite without ALU_XOR_EN; ALUControl=100 and RegWrite in ALUWB with ALU_XOR_EN.
REQ-033 rst raised during MEMWRITE stall -> MemWrite drops 0 asynchronously; after release, state is FETCH.
REQ-034 op=1111111 -> Illegal=1 for one cycle in DECODE, next state FETCH, no write strobes.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control unit: Moore FSM driving datapath selects,
// ALU operation and write strobes for lw/sw/R/I/jal/beq/lui.
// Optional feature: define ALU_XOR_EN to accept funct3=100 (xor) for R/I types.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic       Illegal,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] JAL      = 4'd9;
    localparam logic [3:0] BEQ      = 4'd10;
    localparam logic [3:0] LUI      = 4'd11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b111;
`ifdef ALU_XOR_EN
    localparam logic [2:0] ALU_XOR  = 3'b100;
`endif

    logic [3:0] state, next_state;
    logic       f3_legal, op_legal, illegal_dec;
    logic [2:0] alu_rtype;
    logic       pcw_raw, irw_raw, mw_raw, rw_raw, ill_raw;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    // Instruction legality and R/I-type ALU operation decode
    always_comb begin
        f3_legal  = 1'b0;
        alu_rtype = ALU_ADD;
        case (funct3)
            3'b000: begin f3_legal = 1'b1; alu_rtype = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD; end
            3'b010: begin f3_legal = 1'b1; alu_rtype = ALU_SLT; end
            3'b110: begin f3_legal = 1'b1; alu_rtype = ALU_OR;  end
            3'b111: begin f3_legal = 1'b1; alu_rtype = ALU_AND; end
`ifdef ALU_XOR_EN
            3'b100: begin f3_legal = 1'b1; alu_rtype = ALU_XOR; end
`endif
            default: begin f3_legal = 1'b0; alu_rtype = ALU_ADD; end
        endcase
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ, OP_LUI: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
        illegal_dec = !op_legal || (((op == OP_RTYPE) || (op == OP_ITYPE)) && !f3_legal);
    end

    // Next-state logic; unreachable encodings fall back to FETCH
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                if (illegal_dec) next_state = FETCH;
                else begin
                    case (op)
                        OP_LOAD, OP_STORE: next_state = MEMADR;
                        OP_RTYPE:          next_state = EXECR;
                        OP_ITYPE:          next_state = EXECI;
                        OP_JAL:            next_state = JAL;
                        OP_BEQ:            next_state = BEQ;
                        OP_LUI:            next_state = LUI;
                        default:           next_state = FETCH;
                    endcase
                end
            end
            MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = MemReady ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = MemReady ? FETCH : MEMWRITE;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            JAL:      next_state = ALUWB;
            BEQ:      next_state = FETCH;
            LUI:      next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    // Per-state datapath controls; everything not named in a state stays 0
    always_comb begin
        pcw_raw    = 1'b0;
        irw_raw    = 1'b0;
        mw_raw     = 1'b0;
        rw_raw     = 1'b0;
        ill_raw    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw_raw   = MemReady;
                pcw_raw   = MemReady;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ill_raw = illegal_dec;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                rw_raw    = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mw_raw = 1'b1;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_rtype;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_rtype;
            end
            ALUWB:    rw_raw = 1'b1;
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw_raw = 1'b1;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                pcw_raw    = Zero;
            end
            LUI: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_PASS;
            end
            default: ;
        endcase
    end

    // Immediate format selected directly from the opcode
    always_comb begin
        case (op)
            OP_STORE: ImmSrc = 3'b001;
            OP_BEQ:   ImmSrc = 3'b010;
            OP_JAL:   ImmSrc = 3'b011;
            OP_LUI:   ImmSrc = 3'b100;
            default:  ImmSrc = 3'b000;
        endcase
    end

    // Strobes are masked by reset so nothing is written while rst is high
    always_comb begin
        PCWrite  = pcw_raw & ~rst;
        IRWrite  = irw_raw & ~rst;
        MemWrite = mw_raw  & ~rst;
        RegWrite = rw_raw  & ~rst;
        Illegal  = ill_raw & ~rst;
    end

endmodule
